// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer: data width, NOP encoding, FSM states.
package fetch_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] NOP_ENC = 32'h0000_0013;

  typedef enum logic [1:0] {
    StBoot = 2'd0,
    StRun  = 2'd1,
    StHalt = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Small power-of-two FIFO buffering {instr, pc} pairs toward decode; flush clears it in one cycle.
module fetch_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 64,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             enq,
  input  logic             deq,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q;
  logic [PtrW-1:0]  rd_ptr_q;
  logic [CntW-1:0]  count_q;

  // Pointers wrap naturally because Depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (enq) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(enq) - CntW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) mem_q[wr_ptr_q] <= wdata;
  end

  always_comb begin
    rdata = mem_q[rd_ptr_q];
    full  = (count_q == CntW'(Depth));
    empty = (count_q == '0);
    count = count_q;
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives PC enable/select, handles boot delay, redirect flush and halt,
// and hands fetched instructions to decode through a small FIFO.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned     DEPTH       = 2,
  parameter int unsigned     BOOT_CYCLES = 1,
  parameter logic [XLEN-1:0] NOP         = NOP_ENC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  input  logic [XLEN-1:0] if_instr,
  output logic            pc_en,
  output logic            pc_sel,
  output logic [XLEN-1:0] branch_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt_req,
  output logic            halted,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;
  localparam logic [3:0] BootLast = 4'(BOOT_CYCLES - 1);

  fetch_state_e    state_q, state_d;
  logic [3:0]      boot_cnt_q, boot_cnt_d;
  logic [XLEN-1:0] branch_q, branch_d;

  logic            redirect;
  logic            enq;
  logic            deq;
  logic            fifo_full;
  logic            fifo_empty;
  logic [CntW-1:0] fifo_count;
  logic [2*XLEN-1:0] fifo_rdata;

  fetch_fifo #(
    .Depth (DEPTH),
    .Width (2 * XLEN)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect),
    .enq   (enq),
    .deq   (deq),
    .wdata ({if_instr, if_pc}),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StBoot;
      boot_cnt_q <= '0;
      branch_q   <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      branch_q   <= branch_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    branch_d   = branch_q;
    enq        = 1'b0;

    // Redirects are only honoured once booted.
    redirect = redirect_valid && (state_q != StBoot);

    id_valid = !fifo_empty && !redirect_valid;
    deq      = id_valid && id_ready;

    unique case (state_q)
      StBoot: begin
        boot_cnt_d = boot_cnt_q + 4'd1;
        if (boot_cnt_q == BootLast) state_d = StRun;
      end
      StRun: begin
        enq = !redirect_valid && !halt_req && (!fifo_full || deq);
        if (halt_req && !redirect_valid) state_d = StHalt;
      end
      StHalt: ;
      default: state_d = StBoot;
    endcase

    if (redirect) begin
      state_d  = StRun;
      branch_d = redirect_pc;
    end

    pc_en     = enq || redirect;
    pc_sel    = redirect;
    branch_pc = redirect ? redirect_pc : branch_q;
    halted    = (state_q == StHalt);
    id_instr  = id_valid ? fifo_rdata[2*XLEN-1:XLEN] : NOP;
    id_pc     = id_valid ? fifo_rdata[XLEN-1:0] : '0;
  end

  logic unused_count;
  assign unused_count = ^fifo_count;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: PC register and ROM environment plus a queue-based model.
module tb_fetch_ctrl;

  localparam int unsigned DEPTH       = 2;
  localparam int unsigned BOOT_CYCLES = 1;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  localparam int MBoot = 0;
  localparam int MRun  = 1;
  localparam int MHalt = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        pc_en;
  logic        pc_sel;
  logic [31:0] branch_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt_req;
  logic        halted;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_state;
  int          m_boot;
  logic [63:0] m_q[$];
  logic [31:0] m_branch;

  fetch_ctrl #(
    .DEPTH       (DEPTH),
    .BOOT_CYCLES (BOOT_CYCLES),
    .NOP         (NOP)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .if_pc          (if_pc),
    .if_instr       (if_instr),
    .pc_en          (pc_en),
    .pc_sel         (pc_sel),
    .branch_pc      (branch_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt_req       (halt_req),
    .halted         (halted),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
  endfunction

  // Fetch datapath environment: PC register and next-PC mux.
  always_ff @(posedge clk) begin
    if (rst) if_pc <= 32'h0;
    else if (pc_en) if_pc <= pc_sel ? branch_pc : if_pc + 32'd4;
  end
  assign if_instr = rom(if_pc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state  = MBoot;
    m_boot   = 0;
    m_q.delete();
    m_branch = 32'h0;
  endtask

  // One cycle: drive inputs, compare outputs mid-cycle, advance model at the edge.
  task automatic step(input logic r, input logic rv, input logic [31:0] rp,
                      input logic h, input logic rd);
    logic        e_valid, e_deq, e_enq, e_redir;
    logic [31:0] e_instr, e_pc;
    rst = r; redirect_valid = rv; redirect_pc = rp; halt_req = h; id_ready = rd;
    @(negedge clk);
    e_redir = rv && (m_state != MBoot);
    e_valid = (m_q.size() != 0) && !rv;
    e_deq   = e_valid && rd;
    e_enq   = (m_state == MRun) && !rv && !h && ((m_q.size() < DEPTH) || e_deq);
    e_instr = e_valid ? m_q[0][63:32] : NOP;
    e_pc    = e_valid ? m_q[0][31:0] : 32'h0;
    check("pc_en", {31'b0, pc_en}, {31'b0, e_enq || e_redir});
    check("pc_sel", {31'b0, pc_sel}, {31'b0, e_redir});
    check("branch_pc", branch_pc, e_redir ? rp : m_branch);
    check("halted", {31'b0, halted}, {31'b0, m_state == MHalt});
    check("id_valid", {31'b0, id_valid}, {31'b0, e_valid});
    check("id_instr", id_instr, e_instr);
    check("id_pc", id_pc, e_pc);
    if (r) begin
      model_reset();
    end else if (e_redir) begin
      m_q.delete();
      m_state  = MRun;
      m_branch = rp;
    end else begin
      if (e_deq) void'(m_q.pop_front());
      if (e_enq) m_q.push_back({rom(if_pc), if_pc});
      if (m_state == MBoot) begin
        m_boot++;
        if (m_boot >= BOOT_CYCLES) m_state = MRun;
      end else if (m_state == MRun && h) begin
        m_state = MHalt;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; halt_req = 1'b0; id_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    check("rst_id_instr", id_instr, NOP);
    check("rst_id_pc", id_pc, 32'h0);

    // Boot then steady fetch with decode always ready
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Mid-run reset, then backpressure from the start
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    check("bp_if_pc", if_pc, 32'h8);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Fill, then redirect with a full FIFO
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h100, 1'b0, 1'b0);
    check("redir_if_pc", if_pc, 32'h100);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Halt, drain, resume via redirect
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h200, 1'b0, 1'b1);
    check("halt_resume_pc", if_pc, 32'h200);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Halt and redirect together: redirect wins
    step(1'b0, 1'b1, 32'h300, 1'b1, 1'b1);
    check("conflict_pc", if_pc, 32'h300);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Redirect during boot is ignored
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 32'h400, 1'b0, 1'b1);
    check("boot_redir_pc", if_pc, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    // Reset with a full FIFO
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    check("rst_full_valid", {31'b0, id_valid}, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 11) == 0),
           ($urandom & 32'h0000_FFFC),
           ($urandom_range(0, 14) == 0),
           ($urandom_range(0, 2) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Sequencer for the instruction-fetch datapath (PC register, next-PC mux, instruction ROM).
- Decides each cycle whether the PC advances and whether it loads a redirect target.
- Buffers fetched instruction/PC pairs in a small FIFO toward decode with a valid/ready handshake.
- Handles boot delay, EX-stage redirects (flush) and halt.

Parameters:
- DEPTH, 2, FIFO entries toward decode; power of two, range 2..4.
- BOOT_CYCLES, 1, cycles after reset release before the first fetch is accepted; range 1..15.
- NOP, 32'h0000_0013, value driven on id_instr when id_valid=0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_pc  in  32  current PC from fetch datapath.
- if_instr  in  32  ROM output for if_pc; combinational, valid same cycle.
- pc_en  out  1  PC register update enable (1 = load next_pc at this edge).
- pc_sel  out  1  next-PC select (1 = branch_pc, 0 = pc+4).
- branch_pc  out  32  redirect target to next-PC mux.
- redirect_valid  in  1  EX-stage taken branch/jump, single-cycle pulse.
- redirect_pc  in  32  redirect target; word aligned.
- halt_req  in  1  stop fetching (ebreak/ecall).
- halted  out  1  high while in HALT.
- id_valid  out  1  FIFO head valid to decode.
- id_ready  in  1  decode accepts head.
- id_instr  out  32  head instruction.
- id_pc  out  32  head PC.

Behaviour:
- Reset (rst=1 at edge):
  - state=BOOT, boot counter=0, FIFO count=0, read/write pointers=0.
  - Outputs: pc_en=0, pc_sel=0, branch_pc=0, halted=0, id_valid=0, id_instr=NOP, id_pc=0.
  - Reset mid-operation discards all FIFO contents and returns to BOOT.
- States:
  - BOOT: pc_en=0 and no enqueue. Counter increments each cycle; go to RUN after BOOT_CYCLES cycles. A redirect in BOOT is ignored.
  - RUN: normal fetch.
    - enq = !redirect_valid && !halt_req && (count<DEPTH || deq).
    - pc_en=enq; pc_sel=0.
    - On enq, {if_instr, if_pc} is written at the tail.
    - If halt_req=1 and redirect_valid=0: no enqueue, next state HALT.
  - HALT: pc_en=0, halted=1, FIFO still drains to decode. Exit only via redirect.
- Redirect (RUN or HALT), combinational same cycle:
  - pc_en=1, pc_sel=1, branch_pc=redirect_pc.
  - At the edge: FIFO flushed (count=0, pointers=0), state=RUN.
  - No enqueue that cycle.
  - id_valid is forced 0 while redirect_valid=1, so there is no deq.
  - Redirect beats halt_req in the same cycle.
- When not redirecting, branch_pc holds its last driven value and pc_sel=0.
- Dequeue:
  - deq = id_valid && id_ready.
  - id_valid = (count!=0) && !redirect_valid.
  - id_instr/id_pc show the head entry, or NOP/0 when count=0.
- Count update:
  - count_next = count + enq - deq.
  - Simultaneous enq and deq when full is legal; count stays DEPTH.
  - Pointers wrap modulo DEPTH.
- Latency: an instruction fetched in cycle N is visible on id_* in cycle N+1, provided no redirect occurs in cycle N+1.
- Backpressure: with id_ready=0 and FIFO full, pc_en=0 and the PC holds. Fetch resumes the same cycle id_ready rises (full+deq case).
- Invariant: no PC advance without a corresponding enqueue, except on a redirect.

Decomposition:
- Shared package (core package): NOP encoding, XLEN=32, state enum {BOOT, RUN, HALT}.
- One natural sub-module: fetch_fifo.
  - Parameterised DEPTH, width 64, synchronous active-high clear.
  - Ports: enq, deq, flush, full, empty, count.
  - fetch_ctrl instantiates it and contains only the FSM and handshake logic.

Test Plan:
- Boot: release rst with BOOT_CYCLES=1, id_ready=1, ROM at 0x0 → first cycle pc_en=0; then pc_en=1 every cycle; id_pc sequence 0x0, 0x4, 0x8 starting one cycle after the first enq.
- Backpressure: id_ready=0 for 5 cycles → exactly 2 enqueues, then pc_en=0, if_pc frozen at 0x8. Raise id_ready → deq and enq in the same cycle, count stays 2, order preserved (0x0, 0x4, 0x8).
- Redirect with full FIFO: redirect_valid=1, redirect_pc=0x100 → same cycle pc_sel=1, pc_en=1, branch_pc=0x100, id_valid=0. Next cycle count=0, if_pc=0x100; the following cycle id_pc=0x100.
- Halt: halt_req=1 in RUN → next cycle halted=1, pc_en=0; buffered entries still drain. Redirect to 0x200 → halted=0, fetch resumes at 0x200.
- Conflicts: halt_req and redirect_valid together → RUN, PC=redirect_pc. Redirect during BOOT → ignored, PC unchanged.
- Mid-run reset: rst=1 for 1 cycle with count=2 → id_valid=0, id_instr=NOP, state BOOT, pc_en=0 for BOOT_CYCLES cycles.
